fifo_wm: RTL and testbench

//   Parametrised single-clock circular FIFO. Next generation of the UART/MMIO FIFO.

---
 rtl/fifo_wm_if.sv | 35 +++
 rtl/fifo_wm.sv | 119 +++++++++++
 tb/tb_fifo_wm.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wm_if.sv
// FIFO bus between the MMIO register block (master) and the fifo_wm storage (slave).
// Carries the push/pop handshake, watermark thresholds and status flags.
interface fifo_wm_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CW         = 3
);
    logic                  clear;
    logic                  err_clr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic [CW-1:0]         af_thresh;
    logic [CW-1:0]         ae_thresh;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, err_clr, wr_en, wr_data, rd_en, af_thresh, ae_thresh,
        input  rd_data, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  clear, err_clr, wr_en, wr_data, rd_en, af_thresh, ae_thresh,
        output rd_data, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_wm.sv
// Single-clock circular FIFO of arbitrary depth with FWFT or registered read,
// runtime almost-full/almost-empty watermarks and sticky overflow/underflow flags.
module fifo_wm #(
    parameter int DEPTH      = 5,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = 1,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input logic      clk,
    input logic      arst_n,
    fifo_wm_if.slave bus
);
    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;

    // Depth need not be a power of two, so wrap by compare instead of overflow.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        full   = (count_q == CNT_FULL);
        empty  = (count_q == '0);
        wr_acc = bus.wr_en & ~full  & ~bus.clear;
        rd_acc = bus.rd_en & ~empty & ~bus.clear;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A new error event wins over err_clr in the same cycle; clear wipes both.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.clear) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_en & full)      overflow_q <= 1'b1;
            else if (bus.err_clr)      overflow_q <= 1'b0;
            if (bus.rd_en & empty)     underflow_q <= 1'b1;
            else if (bus.err_clr)      underflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.wr_data;
    end

    always_comb begin
        bus.count        = count_q;
        bus.full         = full;
        bus.empty        = empty;
        bus.almost_full  = (count_q >= bus.af_thresh);
        bus.almost_empty = (count_q <= bus.ae_thresh);
        bus.overflow     = overflow_q;
        bus.underflow    = underflow_q;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            always_comb begin
                bus.rd_data  = empty ? '0 : mem[rd_ptr];
                bus.rd_valid = ~empty;
            end
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (bus.clear) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem[rd_ptr];
                end
            end

            always_comb begin
                bus.rd_data  = rd_data_q;
                bus.rd_valid = rd_valid_q;
            end
        end
    endgenerate
endmodule

// File: tb/tb_fifo_wm.sv
// Directed bench for fifo_wm: a FWFT instance driven from a vector table plus
// hand-written sequences, and a registered-read instance for read latency.
module tb_fifo_wm;
    logic clk;
    logic arst_n;

    fifo_wm_if #(.DATA_WIDTH(8), .CW(3)) a ();
    fifo_wm_if #(.DATA_WIDTH(8), .CW(3)) b ();

    fifo_wm #(.DEPTH(5), .DATA_WIDTH(8), .FWFT(1)) u_fwft (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (a.slave)
    );

    fifo_wm #(.DEPTH(5), .DATA_WIDTH(8), .FWFT(0)) u_reg (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flag vector order: rd_valid, full, empty, almost_full, almost_empty, overflow, underflow
    function automatic logic [6:0] flags_a();
        return {a.rd_valid, a.full, a.empty, a.almost_full, a.almost_empty, a.overflow, a.underflow};
    endfunction

    typedef struct packed {
        logic       clr;
        logic       ecl;
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic [2:0] af;
        logic [2:0] cnt;
        logic [6:0] fl;
        logic [7:0] rd;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t v(input logic clr, input logic ecl, input logic we,
                               input logic [7:0] wd, input logic re, input logic [2:0] af,
                               input logic [2:0] cnt, input logic [6:0] fl, input logic [7:0] rd);
        vec_t r;
        r.clr = clr; r.ecl = ecl; r.we = we; r.wd = wd; r.re = re;
        r.af = af; r.cnt = cnt; r.fl = fl; r.rd = rd;
        return r;
    endfunction

    initial begin
        //                clr ecl we  wd    re af cnt  flags        rd
        vecs[0]  = v(0, 0, 1, 8'h11, 0, 4, 1, 7'b1000100, 8'h11);
        vecs[1]  = v(0, 0, 1, 8'h22, 0, 4, 2, 7'b1000000, 8'h11);
        vecs[2]  = v(0, 0, 1, 8'h33, 0, 4, 3, 7'b1000000, 8'h11);
        vecs[3]  = v(0, 0, 1, 8'h44, 0, 4, 4, 7'b1001000, 8'h11);
        vecs[4]  = v(0, 0, 1, 8'h55, 0, 4, 5, 7'b1101000, 8'h11);
        vecs[5]  = v(0, 0, 1, 8'h66, 0, 4, 5, 7'b1101010, 8'h11);
        vecs[6]  = v(0, 0, 0, 8'h00, 1, 4, 4, 7'b1001010, 8'h22);
        vecs[7]  = v(0, 0, 0, 8'h00, 1, 4, 3, 7'b1000010, 8'h33);
        vecs[8]  = v(0, 0, 0, 8'h00, 1, 4, 2, 7'b1000010, 8'h44);
        vecs[9]  = v(0, 0, 0, 8'h00, 1, 4, 1, 7'b1000110, 8'h55);
        vecs[10] = v(0, 0, 0, 8'h00, 1, 4, 0, 7'b0010110, 8'h00);
        vecs[11] = v(0, 1, 0, 8'h00, 0, 4, 0, 7'b0010100, 8'h00);
        vecs[12] = v(0, 0, 0, 8'h00, 1, 4, 0, 7'b0010101, 8'h00);
        vecs[13] = v(0, 1, 0, 8'h00, 1, 4, 0, 7'b0010101, 8'h00);
        vecs[14] = v(0, 1, 0, 8'h00, 0, 4, 0, 7'b0010100, 8'h00);
        vecs[15] = v(0, 0, 1, 8'h77, 1, 4, 1, 7'b1000101, 8'h77);
        vecs[16] = v(0, 0, 1, 8'h88, 0, 4, 2, 7'b1000001, 8'h77);
        vecs[17] = v(0, 0, 1, 8'h99, 1, 4, 2, 7'b1000001, 8'h88);
        vecs[18] = v(0, 1, 0, 8'h00, 0, 4, 2, 7'b1000000, 8'h88);
        vecs[19] = v(0, 0, 1, 8'hAA, 0, 4, 3, 7'b1000000, 8'h88);
        vecs[20] = v(0, 0, 0, 8'h00, 0, 2, 3, 7'b1001000, 8'h88);
        vecs[21] = v(0, 0, 0, 8'h00, 0, 4, 3, 7'b1000000, 8'h88);
        vecs[22] = v(1, 0, 1, 8'hBB, 0, 4, 0, 7'b0010100, 8'h00);

        arst_n = 1'b0;
        {a.clear, a.err_clr, a.wr_en, a.rd_en} = '0;
        {b.clear, b.err_clr, b.wr_en, b.rd_en} = '0;
        a.wr_data = '0; b.wr_data = '0;
        a.af_thresh = 3'd4; a.ae_thresh = 3'd1;
        b.af_thresh = 3'd4; b.ae_thresh = 3'd1;

        #8;
        chk("reset a count", 32'(a.count), 32'd0);
        chk("reset a flags", 32'(flags_a()), 32'b0010100);
        chk("reset a rd_data", 32'(a.rd_data), 32'h0);
        chk("reset b rd_valid", 32'(b.rd_valid), 32'd0);
        chk("reset b rd_data", 32'(b.rd_data), 32'h0);
        #4 arst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            a.clear = vecs[i].clr; a.err_clr = vecs[i].ecl;
            a.wr_en = vecs[i].we;  a.wr_data = vecs[i].wd;
            a.rd_en = vecs[i].re;  a.af_thresh = vecs[i].af;
            tick();
            chk($sformatf("vec%0d count", i), 32'(a.count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d flags", i), 32'(flags_a()), 32'(vecs[i].fl));
            chk($sformatf("vec%0d rd_data", i), 32'(a.rd_data), 32'(vecs[i].rd));
        end
        {a.clear, a.err_clr, a.wr_en, a.rd_en} = '0;
        a.af_thresh = 3'd4;

        // wrap: pointers start at 0 after clear and cross 4->0 on the second pass
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 3; i++) begin
                a.wr_en = 1'b1; a.wr_data = 8'(32'h20 + p * 3 + i);
                tick();
            end
            a.wr_en = 1'b0;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("wrap p%0d head%0d", p, i), 32'(a.rd_data), 32'h20 + 32'(p * 3 + i));
                a.rd_en = 1'b1;
                tick();
            end
            a.rd_en = 1'b0;
            chk($sformatf("wrap p%0d count", p), 32'(a.count), 32'd0);
        end

        // sustained rd+wr at count 2
        a.wr_en = 1'b1; a.wr_data = 8'h40; tick();
        a.wr_data = 8'h41; tick();
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("rdwr head%0d", k), 32'(a.rd_data), 32'h40 + 32'(k));
            a.wr_en = 1'b1; a.rd_en = 1'b1; a.wr_data = 8'(32'h42 + k);
            tick();
            chk($sformatf("rdwr count%0d", k), 32'(a.count), 32'd2);
        end
        a.wr_en = 1'b0;
        chk("drain head0", 32'(a.rd_data), 32'h4A); tick();
        chk("drain head1", 32'(a.rd_data), 32'h4B); tick();
        a.rd_en = 1'b0;
        chk("drain count", 32'(a.count), 32'd0);
        chk("drain underflow", 32'(a.underflow), 32'd0);

        // full + rd+wr: read wins, write rejected
        for (int i = 0; i < 5; i++) begin
            a.wr_en = 1'b1; a.wr_data = 8'(32'h50 + i); tick();
        end
        chk("fill full", 32'(a.full), 32'd1);
        a.rd_en = 1'b1; a.wr_data = 8'h99; tick();
        a.wr_en = 1'b0; a.rd_en = 1'b0;
        chk("full rdwr count", 32'(a.count), 32'd4);
        chk("full rdwr overflow", 32'(a.overflow), 32'd1);
        chk("full rdwr head", 32'(a.rd_data), 32'h51);
        a.clear = 1'b1; tick(); a.clear = 1'b0;

        // watermark thresholds act combinationally, no clock edge needed
        for (int i = 0; i < 3; i++) begin
            a.wr_en = 1'b1; a.wr_data = 8'(32'h60 + i); tick();
        end
        a.wr_en = 1'b0;
        chk("wm af at 4", 32'(a.almost_full), 32'd0);
        a.af_thresh = 3'd2; #1;
        chk("wm af at 2", 32'(a.almost_full), 32'd1);
        a.ae_thresh = 3'd3; #1;
        chk("wm ae at 3", 32'(a.almost_empty), 32'd1);
        a.af_thresh = 3'd4; a.ae_thresh = 3'd1;

        // registered-read instance
        b.wr_en = 1'b1; b.wr_data = 8'hA5; tick();
        b.wr_en = 1'b0;
        chk("reg idle rd_valid", 32'(b.rd_valid), 32'd0);
        chk("reg count", 32'(b.count), 32'd1);
        b.rd_en = 1'b1; tick();
        b.rd_en = 1'b0;
        chk("reg pop rd_valid", 32'(b.rd_valid), 32'd1);
        chk("reg pop rd_data", 32'(b.rd_data), 32'hA5);
        tick();
        chk("reg pulse end", 32'(b.rd_valid), 32'd0);
        chk("reg hold rd_data", 32'(b.rd_data), 32'hA5);
        b.rd_en = 1'b1; tick();
        b.rd_en = 1'b0;
        chk("reg empty rd_valid", 32'(b.rd_valid), 32'd0);
        chk("reg underflow", 32'(b.underflow), 32'd1);

        // asynchronous reset mid-cycle while a holds 3 words
        #3 arst_n = 1'b0;
        #1;
        chk("arst a count", 32'(a.count), 32'd0);
        chk("arst a flags", 32'(flags_a()), 32'b0010100);
        chk("arst a rd_data", 32'(a.rd_data), 32'h0);
        chk("arst b rd_data", 32'(b.rd_data), 32'h0);
        chk("arst b underflow", 32'(b.underflow), 32'd0);
        #2 arst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
